// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports (wr1 wins)
// and a per-register pending-write scoreboard. Optional macro: REGFILE_BYPASS_EN (write-to-read bypass).
module regfile_mp #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned AW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic                wr0_en_i,
    input  logic [AW-1:0]       wr0_addr_i,
    input  logic [XLEN-1:0]     wr0_data_i,
    input  logic                wr1_en_i,
    input  logic [AW-1:0]       wr1_addr_i,
    input  logic [XLEN-1:0]     wr1_data_i,
    input  logic                issue_en_i,
    input  logic [AW-1:0]       issue_addr_i,
    input  logic                flush_i,
    output logic [AW:0]         busy_cnt_o
);

    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    logic [XLEN-1:0] r_regs [1:NREG-1];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busy_cnt;

    logic            w_wr0_ok;
    logic            w_wr1_ok;
    logic            w_iss_ok;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_cnt_nxt;

    // Address 0 is the zero register; addresses past NREG do not exist.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREG_W);
    endfunction

    assign w_wr0_ok = wr0_en_i   && addr_ok(wr0_addr_i);
    assign w_wr1_ok = wr1_en_i   && addr_ok(wr1_addr_i);
    assign w_iss_ok = issue_en_i && addr_ok(issue_addr_i);

    // Register array; wr1 takes priority on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 1; j < NREG; j++) begin
                r_regs[j] <= '0;
            end
        end else begin
            for (int j = 1; j < NREG; j++) begin
                if (w_wr1_ok && (wr1_addr_i == AW'(j))) begin
                    r_regs[j] <= wr1_data_i;
                end else if (w_wr0_ok && (wr0_addr_i == AW'(j))) begin
                    r_regs[j] <= wr0_data_i;
                end
            end
        end
    end

    // Scoreboard update ordered flush, then writeback clear, then issue set (issue wins).
    always_comb begin
        w_busy_nxt = flush_i ? '0 : r_busy;
        for (int i = 1; i < NREG; i++) begin
            if (w_wr0_ok && (wr0_addr_i == AW'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (w_wr1_ok && (wr1_addr_i == AW'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (w_iss_ok && (issue_addr_i == AW'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign busy_cnt_o = r_busy_cnt;

    // Read ports; everything forced to zero while reset is held.
    always_comb begin
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        logic            w_rb;
        rs_data_o = '0;
        rs_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra = rs_addr_i[k*AW +: AW];
            w_rd = '0;
            w_rb = 1'b0;
            for (int j = 1; j < NREG; j++) begin
                if (w_ra == AW'(j)) begin
                    w_rd = r_regs[j];
                    w_rb = r_busy[j];
                end
            end
`ifdef REGFILE_BYPASS_EN
            // Same-cycle write forwards its data; only a same-cycle re-issue keeps it busy.
            if (w_wr1_ok && (wr1_addr_i == w_ra)) begin
                w_rd = wr1_data_i;
                w_rb = w_iss_ok && (issue_addr_i == w_ra);
            end else if (w_wr0_ok && (wr0_addr_i == w_ra)) begin
                w_rd = wr0_data_i;
                w_rb = w_iss_ok && (issue_addr_i == w_ra);
            end
`endif
            if (!rst) begin
                rs_data_o[k*XLEN +: XLEN] = w_rd;
                rs_busy_o[k]              = w_rb;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values are queued at drive time and popped at sample time.
module tb_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                wr0_en, wr1_en, issue_en, flush;
    logic [AW-1:0]       wr0_addr, wr1_addr, issue_addr;
    logic [XLEN-1:0]     wr0_data, wr1_data;
    logic [AW:0]         busy_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs_addr_i    (rs_addr),
        .rs_data_o    (rs_data),
        .rs_busy_o    (rs_busy),
        .wr0_en_i     (wr0_en),
        .wr0_addr_i   (wr0_addr),
        .wr0_data_i   (wr0_data),
        .wr1_en_i     (wr1_en),
        .wr1_addr_i   (wr1_addr),
        .wr1_data_i   (wr1_data),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .busy_cnt_o   (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int k, input logic [AW-1:0] a);
        rs_addr[k*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rd(input int k);
        return rs_data[k*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] bz(input int k);
        return 32'(rs_busy[k]);
    endfunction

    function automatic logic [31:0] cnt();
        return 32'(busy_cnt);
    endfunction

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rs_addr = '0;
        wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
        issue_en = 0; issue_addr = '0; flush = 0;

        // Reset state
        set_rs(0, 5'd5);
        repeat (2) @(posedge clk);
        #1;
        push("rst_data", 32'h0);  pop_chk(rd(0));
        push("rst_busy", 32'h0);  pop_chk(bz(0));
        push("rst_cnt",  32'h0);  pop_chk(cnt());
        rst = 1'b0;

        // 1. write x5, mark x6, then async reset mid-cycle
        tick();
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        issue_en = 1; issue_addr = 5'd6;
        push("t1_x5_written", 32'hDEADBEEF);
        push("t1_cnt_before_rst", 32'h1);
        tick(); idle();
        pop_chk(rd(0));
        pop_chk(cnt());
        #2 rst = 1'b1;
        #1;
        push("t1_x5_after_rst", 32'h0);  pop_chk(rd(0));
        push("t1_cnt_after_rst", 32'h0); pop_chk(cnt());
        tick();
        rst = 1'b0;

        // 2. dual write same address, write to x0
        wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 5'd3; wr1_data = 32'h22;
        set_rs(0, 5'd3);
        push("t2_wr1_wins", 32'h22);
        tick(); idle();
        pop_chk(rd(0));
        wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'h55;
        tick(); idle();
        set_rs(0, 5'd0);
        #1;
        push("t2_x0_zero", 32'h0); pop_chk(rd(0));
        push("t2_x0_busy", 32'h0); pop_chk(bz(0));

        // 3. issue then writeback
        issue_en = 1; issue_addr = 5'd7;
        set_rs(0, 5'd7);
        push("t3_x7_busy", 32'h1);
        push("t3_cnt_1",   32'h1);
        tick(); idle();
        pop_chk(bz(0));
        pop_chk(cnt());
        wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'hA5;
        push("t3_x7_clear", 32'h0);
        push("t3_cnt_0",    32'h0);
        push("t3_x7_data",  32'hA5);
        tick(); idle();
        pop_chk(bz(0));
        pop_chk(cnt());
        pop_chk(rd(0));

        // 4. issue and writeback same register in one cycle; re-issue
        issue_en = 1; issue_addr = 5'd9;
        wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'h99;
        set_rs(1, 5'd9);
        push("t4_x9_busy", 32'h1);
        push("t4_cnt_1",   32'h1);
        push("t4_x9_data", 32'h99);
        tick(); idle();
        pop_chk(bz(1));
        pop_chk(cnt());
        pop_chk(rd(1));
        issue_en = 1; issue_addr = 5'd9;
        push("t4_reissue_cnt", 32'h1);
        tick(); idle();
        pop_chk(cnt());
        wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'h9;
        push("t4_cleanup_cnt", 32'h0);
        tick(); idle();
        pop_chk(cnt());

        // 5. issue x1..x3, then flush with issue x4
        for (int r = 1; r <= 3; r++) begin
            issue_en = 1; issue_addr = AW'(r);
            tick();
        end
        idle();
        push("t5_cnt_3", 32'h3); pop_chk(cnt());
        flush = 1; issue_en = 1; issue_addr = 5'd4;
        set_rs(0, 5'd4); set_rs(1, 5'd1);
        push("t5_cnt_1",    32'h1);
        push("t5_x4_busy",  32'h1);
        push("t5_x1_clear", 32'h0);
        tick(); idle();
        pop_chk(cnt());
        pop_chk(bz(0));
        pop_chk(bz(1));
        flush = 1;
        tick(); idle();

        // 6. same-cycle write and read
        set_rs(1, 5'd10);
        wr0_en = 1; wr0_addr = 5'd10; wr0_data = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("t6_same_cycle", 32'h1234);
`else
        push("t6_same_cycle", 32'h0);
`endif
        pop_chk(rd(1));
        push("t6_next_cycle", 32'h1234);
        tick(); idle();
        pop_chk(rd(1));

        // dual write bypass priority and issue+write busy on a read port
        set_rs(0, 5'd11); set_rs(1, 5'd12);
        wr0_en = 1; wr0_addr = 5'd11; wr0_data = 32'h1;
        wr1_en = 1; wr1_addr = 5'd11; wr1_data = 32'h2;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("t6_bypass_prio", 32'h2);
`else
        push("t6_bypass_prio", 32'h0);
`endif
        pop_chk(rd(0));
        tick(); idle();
        wr0_en = 1; wr0_addr = 5'd12; wr0_data = 32'h77;
        issue_en = 1; issue_addr = 5'd12;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("t6_iss_wr_data", 32'h77);
        push("t6_iss_wr_busy", 32'h1);
`else
        push("t6_iss_wr_data", 32'h0);
        push("t6_iss_wr_busy", 32'h0);
`endif
        pop_chk(rd(1));
        pop_chk(bz(1));
        push("t6_x11_stored", 32'h2);
        push("t6_x12_busy_after", 32'h1);
        tick(); idle();
        pop_chk(rd(0));
        pop_chk(bz(1));

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
